// File: rtl/mos_diag_collect_if.sv
// Stream bundle between the matrix-multiply engine and the diagonal collector.
//   in_valid/in_data                  : anti-diagonal sum stream (engine -> collector)
//   out_valid/out_data/out_last/out_err : report stream (collector -> consumer)
// The slave modport belongs to the collector. The master modport belongs to
// whatever sits around it: it drives the input stream and sees the report.
interface mos_diag_collect_if #(
  parameter int DW = 40
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_err;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_last, out_err
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_last, out_err
  );
endinterface

// File: rtl/mos_diag_collect.sv
// Collects one anti-diagonal burst from the matrix-multiply engine. The burst
// is 7 beats for a 4x4 matrix and 15 beats for an 8x8. The block buffers the
// burst and sums it. After the burst it reports the saturated sum, then the
// buffered beats newest-first.
//   clk, rst_n : clock, async active-low reset
//   io.in_*    : burst input (contiguous in_valid run)
//   io.out_*   : registered report stream; out_err marks malformed bursts
module mos_diag_collect #(
  parameter int DW    = 40,
  parameter int DEPTH = 15,
  parameter int AW    = 44
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mos_diag_collect_if.slave    io
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t                   state, state_nx;
  logic [DEPTH-1:0][DW-1:0] mem;
  logic [CW-1:0]            cnt, rd, wr_idx;
  logic signed [AW-1:0]     acc, ext;
  logic                     ovf, full, wr_en, err_nx;
  logic [DW-1:0]            sat_acc;
  logic                     o_valid, o_last, o_err;
  logic [DW-1:0]            o_data;

  assign ext    = {{(AW-DW){io.in_data[DW-1]}}, io.in_data};
  assign full   = (cnt == CW'(DEPTH));
  assign err_nx = ovf | ((cnt != CW'(7)) & (cnt != CW'(15)));

  // The sum fits in DW bits only when every bit above the DW sign bit
  // repeats that sign bit. Otherwise clamp toward the sign of the sum.
  always_comb begin
    sat_acc = acc[DW-1:0];
    if (acc[AW-1:DW-1] != {(AW-DW+1){acc[AW-1]}})
      sat_acc = acc[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  // The first beat of a burst is accepted in IDLE. It lands in entry 0 even
  // when cnt still holds the length of the previous burst.
  assign wr_en  = io.in_valid & ((state == IDLE) | ((state == COLLECT) & ~full));
  assign wr_idx = (state == IDLE) ? '0 : cnt;

  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= io.in_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (io.in_valid)  state_nx = COLLECT;
      COLLECT: if (!io.in_valid) state_nx = DRAIN;
      DRAIN:   if (rd == '0)     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rd      <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_valid <= 1'b0;
          o_data  <= '0;
          o_last  <= 1'b0;
          o_err   <= 1'b0;
          if (io.in_valid) begin
            cnt <= CW'(1);
            acc <= ext;
            ovf <= 1'b0;
          end
        end
        COLLECT: begin
          if (io.in_valid) begin
            if (!full) begin
              cnt <= cnt + CW'(1);
              acc <= acc + ext;
            end else begin
              ovf <= 1'b1;
            end
          end else begin
            // The burst has ended. Present the sum first. The error flag
            // latched here stays on every beat of this report.
            o_valid <= 1'b1;
            o_data  <= sat_acc;
            o_last  <= 1'b0;
            o_err   <= err_nx;
            rd      <= cnt - CW'(1);
          end
        end
        DRAIN: begin
          // Input beats arriving now are ignored.
          o_valid <= 1'b1;
          o_data  <= mem[rd];
          o_last  <= (rd == '0);
          if (rd != '0) rd <= rd - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign io.out_valid = o_valid;
  assign io.out_data  = o_data;
  assign io.out_last  = o_last;
  assign io.out_err   = o_err;
endmodule

// File: tb/tb_mos_diag_collect.sv
module tb_mos_diag_collect;
  localparam int DW = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mos_diag_collect_if #(.DW(DW)) io ();

  mos_diag_collect #(.DW(DW), .DEPTH(15), .AW(44)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  typedef struct packed {
    logic [4:0]           n;    // beats driven
    logic [19:0][DW-1:0]  d;    // beat data
    logic [4:0]           rn;   // expected report length
    logic [19:0][DW-1:0]  e;    // expected report words
    logic                 err;  // expected out_err
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one burst, then check its whole report and the idle cycle after
  // it. If pulse_at >= 0, an in_valid pulse is injected while that report
  // beat is on the outputs.
  task automatic run_vec(input int v, input int pulse_at);
    int lat;
    for (int i = 0; i < int'(vecs[v].n); i++) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      io.in_data  = vecs[v].d[i];
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    io.in_data  = '0;
    lat = 0;
    while (!io.out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d latency", v), 64'(lat), 64'd1);
    for (int k = 0; k < int'(vecs[v].rn); k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("v%0d beat%0d valid", v, k), 64'(io.out_valid), 64'd1);
      check($sformatf("v%0d beat%0d data", v, k), 64'(io.out_data), 64'(vecs[v].e[k]));
      check($sformatf("v%0d beat%0d last", v, k), 64'(io.out_last),
            64'(k == int'(vecs[v].rn) - 1));
      check($sformatf("v%0d beat%0d err", v, k), 64'(io.out_err), 64'(vecs[v].err));
      if (k == pulse_at) begin
        io.in_valid = 1'b1;
        io.in_data  = 40'd99;
      end else begin
        io.in_valid = 1'b0;
        io.in_data  = '0;
      end
    end
    @(negedge clk);
    check($sformatf("v%0d idle outs", v),
          {21'd0, io.out_valid, io.out_last, io.out_err, io.out_data}, 64'd0);
  endtask

  initial begin
    int cnt;
    io.in_valid = 1'b0;
    io.in_data  = '0;

    for (int v = 0; v < NV; v++) vecs[v] = '0;
    // 0: nominal 4x4 burst
    vecs[0].n = 7;  for (int i = 0; i < 7; i++) vecs[0].d[i] = 40'(i + 1);
    vecs[0].e[0] = 40'd28; vecs[0].err = 1'b0;
    // 1: positive saturation
    vecs[1].n = 15; for (int i = 0; i < 15; i++) vecs[1].d[i] = 40'h7F_FFFF_FFFF;
    vecs[1].e[0] = 40'h7F_FFFF_FFFF; vecs[1].err = 1'b0;
    // 2: negative sum, no saturation
    vecs[2].n = 7;  for (int i = 0; i < 7; i++) vecs[2].d[i] = 40'hFF_FFFF_FFFF;
    vecs[2].e[0] = 40'hFF_FFFF_FFF9; vecs[2].err = 1'b0;
    // 3: negative saturation
    vecs[3].n = 15; for (int i = 0; i < 15; i++) vecs[3].d[i] = 40'h80_0000_0000;
    vecs[3].e[0] = 40'h80_0000_0000; vecs[3].err = 1'b0;
    // 4: short burst
    vecs[4].n = 5;  for (int i = 0; i < 5; i++) vecs[4].d[i] = 40'(10 * (i + 1));
    vecs[4].e[0] = 40'd150; vecs[4].err = 1'b1;
    // 5: overlong burst; beats 16 and 17 are dropped
    vecs[5].n = 17; for (int i = 0; i < 17; i++) vecs[5].d[i] = 40'(i + 1);
    vecs[5].e[0] = 40'd120; vecs[5].err = 1'b1;
    // 6: single-beat burst
    vecs[6].n = 1;  vecs[6].d[0] = 40'd5;
    vecs[6].e[0] = 40'd5; vecs[6].err = 1'b1;
    // The report echoes the kept beats newest-first.
    for (int v = 0; v < NV; v++) begin
      cnt = (int'(vecs[v].n) > 15) ? 15 : int'(vecs[v].n);
      vecs[v].rn = 5'(cnt + 1);
      for (int k = 1; k <= cnt; k++) vecs[v].e[k] = vecs[v].d[cnt - k];
    end

    repeat (3) @(negedge clk);
    check("reset outs", {21'd0, io.out_valid, io.out_last, io.out_err, io.out_data}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      run_vec(v, -1);
      @(negedge clk);
    end

    // Reset while a 15-beat report is draining.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      io.in_data  = 40'(i + 1);
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    io.in_data  = '0;
    repeat (4) @(negedge clk);
    check("mid-drain valid", 64'(io.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async reset outs", {21'd0, io.out_valid, io.out_last, io.out_err, io.out_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset outs", {21'd0, io.out_valid, io.out_last, io.out_err, io.out_data}, 64'd0);
    run_vec(0, -1);
    @(negedge clk);

    // in_valid pulse during DRAIN must not disturb the report.
    run_vec(0, 3);
    @(negedge clk);
    run_vec(4, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end
endmodule
